// File: rtl/exe_pkg.sv
// Shared EXE-stage types for the iterative normalizer.
package exe_pkg;
  typedef enum logic [1:0] {NORM_CLZ = 2'b00, NORM_CTZ = 2'b01} norm_cmd_t;
  typedef enum logic [1:0] {NORM_IDLE, NORM_RUN, NORM_DONE} norm_state_t;
endpackage

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal; lets CTZ reuse the CLZ search.
module bit_reverse #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign dout[i] = din[WIDTH-1-i];
  end
endmodule

// File: rtl/normalizer.sv
// Iterative CLZ/CTZ counter and normalizer: one binary-search stage per clock,
// fixed latency, no early-out.
module normalizer
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START_SE,
  input  logic [1:0]               CMD_SE,
  input  logic [WIDTH-1:0]         DIN_SE,
  input  logic                     FLUSH_SE,
  output logic                     BUSY_SE,
  output logic                     DONE_SE,
  output logic [$clog2(WIDTH):0]   COUNT_SE,
  output logic [WIDTH-1:0]         DOUT_SE,
  output logic                     ZERO_SE
);
  localparam int STAGES = $clog2(WIDTH);
  localparam int CNT_W  = STAGES + 1;
  localparam int SW     = $clog2(STAGES);

  norm_state_t      state_q, state_d;
  logic [WIDTH-1:0] work_q, work_nx, din_rev, res_rev;
  logic [CNT_W-1:0] cnt_q, cnt_nx, k;
  logic [SW-1:0]    stage_q;
  logic             ctz_q, zero_q, is_ctz, start_ok, hit;

  // Reserved commands fall through to CLZ.
  assign is_ctz   = (CMD_SE == NORM_CTZ);
  assign start_ok = START_SE && !FLUSH_SE;

  bit_reverse #(.WIDTH(WIDTH)) u_rev_load (.din(DIN_SE),  .dout(din_rev));
  bit_reverse #(.WIDTH(WIDTH)) u_rev_res  (.din(work_nx), .dout(res_rev));

  // One search stage: if the top k bits are clear, shift them out.
  always_comb begin
    k       = CNT_W'(1) << stage_q;
    hit     = (work_q >> (CNT_W'(WIDTH) - k)) == '0;
    work_nx = hit ? (work_q << k) : work_q;
    cnt_nx  = hit ? (cnt_q + k) : cnt_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= NORM_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORM_IDLE: if (start_ok) state_d = NORM_RUN;
      NORM_RUN: begin
        if (FLUSH_SE)           state_d = NORM_IDLE;
        else if (stage_q == '0) state_d = NORM_DONE;
      end
      NORM_DONE: state_d = NORM_IDLE;
      default:   state_d = NORM_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      work_q   <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      ctz_q    <= 1'b0;
      zero_q   <= 1'b0;
      COUNT_SE <= '0;
      DOUT_SE  <= '0;
      ZERO_SE  <= 1'b0;
    end else begin
      case (state_q)
        NORM_IDLE: if (start_ok) begin
          work_q  <= is_ctz ? din_rev : DIN_SE;
          cnt_q   <= '0;
          stage_q <= SW'(STAGES - 1);
          zero_q  <= (DIN_SE == '0);
          ctz_q   <= is_ctz;
        end
        NORM_RUN: if (!FLUSH_SE) begin
          work_q  <= work_nx;
          cnt_q   <= cnt_nx;
          stage_q <= stage_q - SW'(1);
          // Results land on the edge entering DONE; search caps at WIDTH-1.
          if (stage_q == '0) begin
            COUNT_SE <= zero_q ? CNT_W'(WIDTH) : cnt_nx;
            DOUT_SE  <= zero_q ? '0 : (ctz_q ? res_rev : work_nx);
            ZERO_SE  <= zero_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY_SE = (state_q != NORM_IDLE);
  assign DONE_SE = (state_q == NORM_DONE);
endmodule

// File: tb/tb_normalizer.sv
// Directed + randomized check of normalizer against a bit-scan reference model.
module tb_normalizer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START_SE = 1'b0;
  logic [1:0]  CMD_SE = 2'b00;
  logic [31:0] DIN_SE = '0;
  logic        FLUSH_SE = 1'b0;
  logic        BUSY_SE, DONE_SE, ZERO_SE;
  logic [5:0]  COUNT_SE;
  logic [31:0] DOUT_SE;

  int compared = 0;
  int mismatched = 0;
  int last_cnt;
  logic [31:0] last_dout;

  normalizer #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .START_SE(START_SE), .CMD_SE(CMD_SE),
    .DIN_SE(DIN_SE), .FLUSH_SE(FLUSH_SE), .BUSY_SE(BUSY_SE), .DONE_SE(DONE_SE),
    .COUNT_SE(COUNT_SE), .DOUT_SE(DOUT_SE), .ZERO_SE(ZERO_SE)
  );

  always #5 CLK = ~CLK;

  function automatic int ref_cnt(input logic [1:0] cmd, input logic [31:0] d);
    if (d == 0) return 32;
    if (cmd == 2'b01) begin
      for (int i = 0; i < 32; i++) if (d[i]) return i;
    end else begin
      for (int i = 31; i >= 0; i--) if (d[i]) return 31 - i;
    end
    return 32;
  endfunction

  function automatic logic [31:0] ref_dout(input logic [1:0] cmd, input logic [31:0] d);
    int c;
    c = ref_cnt(cmd, d);
    if (d == 0) return '0;
    return (cmd == 2'b01) ? (d >> c) : (d << c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits for DONE, counting edges since the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!DONE_SE && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] cmd, input logic [31:0] din);
    chk({tag, " count"}, COUNT_SE, ref_cnt(cmd, din));
    chk({tag, " dout"},  DOUT_SE,  ref_dout(cmd, din));
    chk({tag, " zero"},  ZERO_SE,  din == 0);
    last_cnt  = ref_cnt(cmd, din);
    last_dout = ref_dout(cmd, din);
  endtask

  task automatic do_op(input string tag, input logic [1:0] cmd, input logic [31:0] din);
    int n;
    START_SE = 1'b1; CMD_SE = cmd; DIN_SE = din;
    tick();
    START_SE = 1'b0; DIN_SE = $urandom;
    chk({tag, " busy"}, BUSY_SE, 1);
    wait_done(n);
    chk({tag, " latency"}, n, 5);
    check_result(tag, cmd, din);
    tick();
    chk({tag, " idle"}, {DONE_SE, BUSY_SE}, 2'b00);
  endtask

  initial begin
    int n, dones;
    logic [31:0] d;
    logic [1:0]  c;

    // Reset state
    #2;
    chk("reset outs", {BUSY_SE, DONE_SE, ZERO_SE, COUNT_SE, DOUT_SE}, '0);
    tick(); tick();
    RESET = 1'b0;
    tick();
    chk("post-reset idle", {BUSY_SE, DONE_SE}, 2'b00);

    // Directed values
    do_op("clz 0x10000", 2'b00, 32'h0001_0000);
    do_op("ctz 0xA00",   2'b01, 32'h0000_0A00);
    do_op("clz msb",     2'b00, 32'h8000_0000);
    do_op("clz zero",    2'b00, 32'h0);
    do_op("ctz zero",    2'b01, 32'h0);
    do_op("ctz lsb",     2'b01, 32'h0000_0001);
    do_op("rsvd cmd",    2'b11, 32'h0000_0300);

    // Second START during RUN is ignored
    START_SE = 1'b1; CMD_SE = 2'b00; DIN_SE = 32'hFFFF_FFFF;
    tick();
    START_SE = 1'b0;
    tick();
    START_SE = 1'b1; DIN_SE = 32'h1;
    tick();
    START_SE = 1'b0;
    dones = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE_SE) begin
        dones++;
        chk("ign start count", COUNT_SE, 0);
        chk("ign start dout", DOUT_SE, 32'hFFFF_FFFF);
      end else if (dones == 0) n += BUSY_SE ? 0 : 1;
      tick();
    end
    chk("ign start dones", dones, 1);
    chk("ign start busy gaps", n, 0);
    last_cnt = 0; last_dout = 32'hFFFF_FFFF;

    // START held through DONE: ignored in DONE, accepted the cycle after
    START_SE = 1'b1; CMD_SE = 2'b01; DIN_SE = 32'h0000_1000;
    tick();
    START_SE = 1'b0;
    wait_done(n);
    chk("done-start latency", n, 5);
    START_SE = 1'b1; CMD_SE = 2'b00; DIN_SE = 32'h0000_00FF;
    tick();
    chk("start in done ignored", BUSY_SE, 0);
    tick();
    START_SE = 1'b0;
    chk("start after done", BUSY_SE, 1);
    wait_done(n);
    chk("after-done latency", n, 5);
    check_result("after-done", 2'b00, 32'h0000_00FF);
    tick();

    // FLUSH in RUN cycle 3
    START_SE = 1'b1; CMD_SE = 2'b00; DIN_SE = 32'h0000_0001;
    tick();
    START_SE = 1'b0;
    tick(); tick();
    FLUSH_SE = 1'b1;
    tick();
    FLUSH_SE = 1'b0;
    chk("flush idle", BUSY_SE, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      dones += DONE_SE ? 1 : 0;
      tick();
    end
    chk("flush no done", dones, 0);
    chk("flush count kept", COUNT_SE, last_cnt);
    chk("flush dout kept", DOUT_SE, last_dout);

    // FLUSH + START in IDLE
    FLUSH_SE = 1'b1; START_SE = 1'b1; DIN_SE = 32'h10;
    tick();
    FLUSH_SE = 1'b0; START_SE = 1'b0;
    chk("flush+start", BUSY_SE, 0);

    // FLUSH in DONE: pulse stands, results kept
    START_SE = 1'b1; CMD_SE = 2'b01; DIN_SE = 32'h0000_8000;
    tick();
    START_SE = 1'b0;
    wait_done(n);
    FLUSH_SE = 1'b1;
    #1;
    chk("flush in done pulse", DONE_SE, 1);
    tick();
    FLUSH_SE = 1'b0;
    chk("flush in done idle", {DONE_SE, BUSY_SE}, 2'b00);
    chk("flush in done count", COUNT_SE, 15);

    // RESET mid-RUN, between edges
    START_SE = 1'b1; CMD_SE = 2'b00; DIN_SE = 32'h0000_0100;
    tick();
    START_SE = 1'b0;
    tick();
    #2 RESET = 1'b1;
    #1;
    chk("async reset outs", {BUSY_SE, DONE_SE, ZERO_SE, COUNT_SE, DOUT_SE}, '0);
    tick();
    #1 RESET = 1'b0;
    tick();
    do_op("clz after reset", 2'b00, 32'h00F0_0000);

    // Randomized operands with varied leading/trailing zero runs
    for (int i = 0; i < 40; i++) begin
      c = 2'($urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 4))
        0: d = d >> $urandom_range(0, 31);
        1: d = d << $urandom_range(0, 31);
        2: d = 32'h1 << $urandom_range(0, 31);
        3: d = (i % 8 == 0) ? 32'h0 : d;
        default: ;
      endcase
      do_op("random", c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
